// File: rtl/addsub_acc_pkg.sv
// Shared definitions for the add/subtract accumulator: command opcodes,
// control-state encoding, result-flag bundle and saturation limits.
package addsub_acc_pkg;

    // Command opcodes carried on in_op.
    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    // Control states: accept a command, execute it, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Status flags produced alongside each accumulator update.
    typedef struct packed {
        logic carry;   // ADD: carry out of MSB; SUB: borrow
        logic ovf;     // signed overflow
        logic zero;    // result is all zeros
        logic neg;     // result sign bit
    } acc_flags_t;

    // Largest signed value representable in 'width' bits (0111..1).
    // Returned wide; callers cast down to their own width.
    function automatic logic [63:0] sat_max_val(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative signed value representable in 'width' bits (1000..0).
    function automatic logic [63:0] sat_min_val(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage : addsub_acc_pkg

// File: rtl/acc_addsub_core.sv
// Combinational WIDTH-bit ripple adder-subtractor.
// Subtraction is done as a + ~b + 1: the operand is inverted by XOR with
// 'sub' and 'sub' itself feeds the carry-in of the least significant stage.
module acc_addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_raw,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_x;   // operand after conditional inversion
    logic [WIDTH:0]   w_c;     // carry chain, w_c[i] is the carry into bit i

    assign w_b_x  = b ^ {WIDTH{sub}};
    assign w_c[0] = sub;

    // One full adder per bit, rippling the carry from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ w_b_x[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & w_b_x[i]) | (w_c[i] & (a[i] ^ w_b_x[i]));
    end

    // Raw carry out of the MSB; signed overflow is a disagreement between
    // the carry into and the carry out of the sign bit.
    assign carry_raw = w_c[WIDTH];
    assign ovf       = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule : acc_addsub_core

// File: rtl/addsub_accumulator.sv
// Accumulator stage: accepts one {op, operand} command per in_valid/in_ready
// handshake, applies it to the internal accumulator in a single execute
// cycle, and presents the new value with flags through out_valid/out_ready.
// Control flow is IDLE -> EXEC -> RESP -> IDLE, so at most one command is in
// flight and commands offered while busy are simply not accepted.
module addsub_accumulator #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [7:0]       op_count
);

    import addsub_acc_pkg::*;

    // Saturation limits sized to this instance.
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_val(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_val(WIDTH));

    // ------------------------------------------------------------------
    // State and registered datapath
    // ------------------------------------------------------------------
    state_e           r_state;
    op_e              r_op;         // captured command opcode
    logic [WIDTH-1:0] r_operand;    // captured command operand
    logic [WIDTH-1:0] r_acc;        // accumulator, also the visible result
    acc_flags_t       r_flags;      // flags of the last executed command
    logic [7:0]       r_op_count;   // completed (delivered) commands

    // ------------------------------------------------------------------
    // Combinational control and datapath
    // ------------------------------------------------------------------
    state_e           w_next_state;
    logic             w_accept;     // command handshake completes this cycle
    logic             w_exec;       // accumulator updates this cycle
    logic             w_complete;   // result handshake completes this cycle

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_raw;
    logic             w_core_ovf;

    logic [WIDTH-1:0] w_res_acc;
    acc_flags_t       w_res_flags;

    // Adder-subtractor core always sees the current accumulator and the
    // captured operand; its result is only committed during EXEC.
    assign w_sub = (r_op == OP_SUB);

    acc_addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (r_acc),
        .b         (r_operand),
        .sub       (w_sub),
        .sum       (w_sum),
        .carry_raw (w_carry_raw),
        .ovf       (w_core_ovf)
    );

    // Next-state decode and handshake outputs for the three-state controller.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // that forgets an assignment can infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        w_complete   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec       = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // New accumulator value and flags for the captured command, including
    // the optional clamp on signed overflow.
    always_comb begin
        w_res_acc   = r_acc;
        w_res_flags = '0;

        case (r_op)
            OP_CLR: begin
                w_res_acc = '0;
            end
            OP_LOAD: begin
                w_res_acc = r_operand;
            end
            OP_ADD, OP_SUB: begin
                w_res_acc         = w_sum;
                // The core reports a true carry; for subtraction a missing
                // carry means the operand was larger, i.e. a borrow.
                w_res_flags.carry = w_sub ? ~w_carry_raw : w_carry_raw;
                w_res_flags.ovf   = w_core_ovf;
                // On overflow the wrapped sign is the opposite of the true
                // sign: a negative-looking result came from a positive
                // overflow and clamps to the positive limit, and vice versa.
                if (SAT && w_core_ovf) begin
                    w_res_acc = w_sum[WIDTH-1] ? SAT_MAX : SAT_MIN;
                end
            end
            default: begin
                w_res_acc = r_acc;
            end
        endcase

        // Zero and sign always describe the value actually stored.
        w_res_flags.zero = (w_res_acc == '0);
        w_res_flags.neg  = w_res_acc[WIDTH-1];
    end

    // Control state register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the command at the moment it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_CLR;
            r_operand <= '0;
        end else if (w_accept) begin
            r_op      <= op_e'(in_op);
            r_operand <= in_data;
        end
    end

    // Accumulator and flags change only in EXEC and hold otherwise, which
    // keeps the result stable for the whole RESP phase under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_flags <= '0;
        end else if (w_exec) begin
            r_acc   <= w_res_acc;
            r_flags <= w_res_flags;
        end
    end

    // Count delivered results; the counter wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= 8'd0;
        end else if (w_complete) begin
            r_op_count <= r_op_count + 8'd1;
        end
    end

    // Result outputs are the registered accumulator and flags directly.
    assign out_acc   = r_acc;
    assign out_carry = r_flags.carry;
    assign out_ovf   = r_flags.ovf;
    assign out_zero  = r_flags.zero;
    assign out_neg   = r_flags.neg;
    assign op_count  = r_op_count;

endmodule : addsub_accumulator

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator (WIDTH=8). Expected results
// come from an arithmetic reference model using plain integer math.
module tb_addsub_accumulator;

    localparam int WIDTH = 8;
    parameter  bit SAT   = 1'b0;

    localparam logic [1:0] C_CLR  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_SUB  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_acc;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic [7:0]       op_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0] m_acc;
    logic       m_carry;
    logic       m_ovf;
    logic [7:0] m_cnt;

    addsub_accumulator #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed result as {acc, carry, ovf, zero, neg}
    function automatic logic [11:0] obs_vec();
        return {out_acc, out_carry, out_ovf, out_zero, out_neg};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {m_acc, m_carry, m_ovf, (m_acc == 8'd0), m_acc[7]};
    endfunction

    task automatic model_reset();
        m_acc   = 8'd0;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 8'd0;
    endtask

    // Apply one command using signed/unsigned integer arithmetic.
    task automatic model_apply(input logic [1:0] op, input logic [7:0] d);
        int ur;
        int sa;
        int sb;
        int sr;
        sa = $signed(m_acc);
        sb = $signed(d);
        case (op)
            C_CLR: begin
                m_acc = 8'd0; m_carry = 1'b0; m_ovf = 1'b0;
            end
            C_LOAD: begin
                m_acc = d; m_carry = 1'b0; m_ovf = 1'b0;
            end
            default: begin
                if (op == C_ADD) begin
                    ur      = int'(m_acc) + int'(d);
                    sr      = sa + sb;
                    m_carry = (ur > 255);
                end else begin
                    ur      = int'(m_acc) - int'(d);
                    sr      = sa - sb;
                    m_carry = (d > m_acc);
                end
                m_ovf = (sr > 127) || (sr < -128);
                m_acc = ur[7:0];
                if (SAT && m_ovf) m_acc = (sr > 127) ? 8'h7F : 8'h80;
            end
        endcase
    endtask

    // Offer a command, wait for acceptance, then wait for out_valid.
    // Returns at a falling edge with out_valid sampled; 'lat' counts falling
    // edges after the accepting rising edge up to and including that one.
    task automatic issue(input logic [1:0] op, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    // Accept the presented result; returns 1 time unit after the transfer edge.
    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (obs_vec() !== 12'h000) begin
            n_fails++; $display("FAIL reset acc/flags: got %h expected 000", obs_vec());
        end
        n_checks++;
        if (op_count !== 8'd0) begin
            n_fails++; $display("FAIL reset op_count: got %0d expected 0", op_count);
        end
    endtask

    task automatic test_load_add();
        logic [1:0] ops [2];
        logic [7:0] dat [2];
        int lat;
        ops = '{C_LOAD, C_ADD};
        dat = '{8'h05, 8'h03};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], dat[i], lat);
            model_apply(ops[i], dat[i]);
            n_checks++;
            if (lat !== 2) begin
                n_fails++; $display("FAIL load_add latency[%0d]: got %0d expected 2", i, lat);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL load_add result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            release_result();
            n_checks++;
            if (op_count !== m_cnt) begin
                n_fails++; $display("FAIL load_add op_count[%0d]: got %0d expected %0d", i, op_count, m_cnt);
            end
        end
        n_checks++;
        if (out_acc !== 8'h08 || op_count !== 8'd2) begin
            n_fails++; $display("FAIL load_add final: got acc %h cnt %0d expected acc 08 cnt 2", out_acc, op_count);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] ops [2];
        logic [7:0] dat [2];
        int lat;
        ops = '{C_LOAD, C_ADD};
        dat = '{8'h7F, 8'h01};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], dat[i], lat);
            model_apply(ops[i], dat[i]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL overflow result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            release_result();
        end
        n_checks++;
        if (out_acc !== (SAT ? 8'h7F : 8'h80) || out_ovf !== 1'b1) begin
            n_fails++; $display("FAIL overflow final: got acc %h ovf %b expected acc %h ovf 1",
                                out_acc, out_ovf, SAT ? 8'h7F : 8'h80);
        end
    endtask

    task automatic test_sub_borrow();
        logic [1:0] ops [3];
        logic [7:0] dat [3];
        int lat;
        ops = '{C_LOAD, C_SUB, C_SUB};
        dat = '{8'h03, 8'h05, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], dat[i], lat);
            model_apply(ops[i], dat[i]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL sub_borrow result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            release_result();
        end
    endtask

    task automatic test_carry_clear();
        logic [1:0] ops [3];
        logic [7:0] dat [3];
        int lat;
        ops = '{C_LOAD, C_ADD, C_CLR};
        dat = '{8'hFF, 8'h01, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], dat[i], lat);
            model_apply(ops[i], dat[i]);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL carry_clear result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] snap;
        issue(C_ADD, 8'h11, lat);
        model_apply(C_ADD, 8'h11);
        snap = exp_vec();
        n_checks++;
        if (obs_vec() !== snap) begin
            n_fails++; $display("FAIL backpressure result: got %h expected %h", obs_vec(), snap);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; in_op = C_LOAD; in_data = 8'hA5;
            end
            if (i == 6) in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs_vec() !== snap) begin
                n_fails++; $display("FAIL backpressure hold[%0d]: got v=%b r=%b res=%h expected v=1 r=0 res=%h",
                                    i, out_valid, in_ready, obs_vec(), snap);
            end
        end
        release_result();
        n_checks++;
        if (op_count !== m_cnt) begin
            n_fails++; $display("FAIL backpressure op_count: got %0d expected %0d", op_count, m_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_vec() !== snap) begin
                n_fails++; $display("FAIL backpressure after[%0d]: got v=%b r=%b res=%h expected v=0 r=1 res=%h",
                                    i, out_valid, in_ready, obs_vec(), snap);
            end
        end
    endtask

    task automatic test_reset_in_exec();
        @(negedge clk);
        in_valid = 1'b1; in_op = C_ADD; in_data = 8'h22;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 8'd0 || op_count !== 8'd0) begin
            n_fails++; $display("FAIL reset_exec state: got v=%b r=%b acc=%h cnt=%0d expected v=0 r=1 acc=00 cnt=0",
                                out_valid, in_ready, out_acc, op_count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fails++; $display("FAIL reset_exec no_pulse[%0d]: got %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random_wrap();
        int lat;
        logic [1:0] op;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            issue(op, d, lat);
            model_apply(op, d);
            n_checks++;
            if (lat !== 2 || obs_vec() !== exp_vec()) begin
                n_fails++; $display("FAIL random[%0d] op=%0d d=%h: got lat=%0d res=%h expected lat=2 res=%h",
                                    i, op, d, lat, obs_vec(), exp_vec());
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result();
            n_checks++;
            if (op_count !== m_cnt) begin
                n_fails++; $display("FAIL random[%0d] op_count: got %0d expected %0d", i, op_count, m_cnt);
            end
        end
        n_checks++;
        if (op_count !== 8'd0) begin
            n_fails++; $display("FAIL random wrap: got op_count %0d expected 0", op_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        test_reset();
        test_load_add();
        test_overflow();
        test_sub_borrow();
        test_carry_clear();
        test_backpressure();
        test_reset_in_exec();
        test_random_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_addsub_accumulator
